// File: rtl/free_list_pkg.sv
// rtl/free_list_pkg.sv - shared sizes and types for the physical register free list
package free_list_pkg;

   localparam int NUM_PREGS = 64;
   localparam int NUM_AREGS = 32;
   localparam int DEPTH     = NUM_PREGS - NUM_AREGS;

   // physical register index
   typedef logic [$clog2(NUM_PREGS)-1:0] phys_reg_t;

   // FIFO pointer: index bits plus one wrap bit
   typedef logic [$clog2(DEPTH):0] ptr_t;

   // free entry count spans 0..DEPTH, so it shares the pointer width
   typedef ptr_t count_t;

endpackage

// File: rtl/free_list_if.sv
// rtl/free_list_if.sv - rename/commit side signals of the free list
interface free_list_if;
   import free_list_pkg::*;

   logic      alloc_req;
   logic      alloc_valid;
   phys_reg_t alloc_pd;
   logic      free_we;
   phys_reg_t free_pd;
   logic      commit_alloc;
   logic      flush;
   logic      empty;
   count_t    free_count;

   // pipeline side: requests, returns registers, reports commits and flushes
   modport master (
      output alloc_req, free_we, free_pd, commit_alloc, flush,
      input  alloc_valid, alloc_pd, empty, free_count
   );

   // free list side
   modport slave (
      input  alloc_req, free_we, free_pd, commit_alloc, flush,
      output alloc_valid, alloc_pd, empty, free_count
   );

endinterface

// File: rtl/free_list.sv
// rtl/free_list.sv - physical register free list FIFO; flush recovery under FREE_LIST_FLUSH_RECOVERY_EN
module free_list
   import free_list_pkg::*;
#(
   parameter int NUM_PREGS = free_list_pkg::NUM_PREGS,
   parameter int NUM_AREGS = free_list_pkg::NUM_AREGS
) (
   input logic        clk,
   input logic        rst,
   free_list_if.slave bus
);

   // DEPTH must be a power of two so the pointers wrap by plain overflow
   localparam int DEPTH = NUM_PREGS - NUM_AREGS;
   localparam int IW    = $clog2(DEPTH);
   localparam int PW    = $clog2(NUM_PREGS);

   typedef logic [IW:0]   lptr_t;
   typedef logic [PW-1:0] preg_t;

   preg_t entries [DEPTH];
   lptr_t head;
   lptr_t tail;
   lptr_t head_nxt;
   logic  is_empty;
   logic  is_full;
   logic  pop;
   logic  push;
   logic  flush_now;

   assign is_empty = (head == tail);
   assign is_full  = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);

   // head entry is presented without latency; a freed register is never bypassed to it
   assign bus.alloc_valid = !is_empty;
   assign bus.empty       = is_empty;
   assign bus.alloc_pd    = entries[head[IW-1:0]];
   assign bus.free_count  = tail - head;

   assign pop  = bus.alloc_req && !is_empty && !flush_now;
   assign push = bus.free_we && (bus.free_pd != '0) && (!is_full || pop);

`ifdef FREE_LIST_FLUSH_RECOVERY_EN
   lptr_t commit_head;
   lptr_t commit_head_nxt;

   assign flush_now = bus.flush;

   // committed head trails head and is clamped so it never overtakes it
   always_comb begin
      commit_head_nxt = commit_head;
      if (bus.commit_alloc && (commit_head != head)) begin
         commit_head_nxt = commit_head + lptr_t'(1);
      end
   end

   // committed head register
   always_ff @(posedge clk) begin
      if (rst) begin
         commit_head <= '0;
      end else begin
         commit_head <= commit_head_nxt;
      end
   end

   // flush rewinds head to the committed point, otherwise a granted alloc advances it
   always_comb begin
      head_nxt = head;
      if (flush_now) begin
         head_nxt = commit_head_nxt;
      end else if (pop) begin
         head_nxt = head + lptr_t'(1);
      end
   end
`else
   logic unused_recovery;

   assign flush_now       = 1'b0;
   assign unused_recovery = bus.flush | bus.commit_alloc;

   // head advances only on a granted alloc
   always_comb begin
      head_nxt = head;
      if (pop) begin
         head_nxt = head + lptr_t'(1);
      end
   end
`endif

   // pointers and storage; reset loads NUM_AREGS.. as a full list
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= lptr_t'(DEPTH);
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= preg_t'(NUM_AREGS + i);
         end
      end else begin
         head <= head_nxt;
         if (push) begin
            entries[tail[IW-1:0]] <= bus.free_pd;
            tail                  <= tail + lptr_t'(1);
         end
      end
   end

   // a return into a full list with no simultaneous alloc would lose a register
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(bus.free_we && (bus.free_pd != '0) && is_full && !pop));
      end
   end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter NUM_PREGS, default 64, total physical registers.
REQ-002 Parameter NUM_AREGS, default 32, architectural registers; FIFO depth = NUM_PREGS-NUM_AREGS.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 alloc_req  input  1  rename requests one physical register this cycle.
REQ-006 alloc_valid  output  1  a free register is available (list not empty).
REQ-007 alloc_pd  output  $clog2(NUM_PREGS)  free register at head; drives RAT pd_dispatch.
REQ-008 free_we  input  1  commit returns a stale physical register.
REQ-009 free_pd  input  $clog2(NUM_PREGS)  register being returned.
REQ-010 commit_alloc  input  1  a committing instruction had allocated a register (advances committed head).
REQ-011 flush  input  1  pipeline flush; discard all uncommitted allocations.
REQ-012 empty  output  1  no free registers.
REQ-013 free_count  output  $clog2(depth)+1  number of free entries.

Function
REQ-014 Storage: circular array of depth entries; head, tail, commit_head pointers carry one extra wrap bit.
REQ-015 alloc_pd = entries[head], combinational; alloc_valid = !empty; zero-latency read.
REQ-016 alloc_req && alloc_valid: head increments at posedge; alloc_req && !alloc_valid: no state change, no pop.
REQ-017 free_we && free_pd != 0: entries[tail] <= free_pd, tail increments; free_pd == 0 ignored.
REQ-018 Simultaneous pop and push: both occur; count unchanged; no bypass of freed register to alloc_pd in same cycle (empty-list alloc denied even if free_we).
REQ-019 empty when head == tail (wrap bits equal); full when indices equal and wrap bits differ.
REQ-020 Push while full is illegal; the block SHALL hold state and assert error in simulation.
REQ-021 commit_alloc increments commit_head; commit_head never passes head.
REQ-022 Wrap-around: all pointers wrap modulo depth, toggling wrap bit.
REQ-023 free_count = tail - head (with wrap bit), registered-consistent each cycle.

Reset
REQ-024 On rst: entries[i] = NUM_AREGS+i; head = commit_head = 0; tail = depth with wrap bit set (full).
REQ-025 Post-reset outputs: alloc_valid=1, alloc_pd=NUM_AREGS (32), empty=0, free_count=depth (32).
REQ-026 rst overrides flush, alloc, free in same cycle.

Configuration
REQ-027 Macro FREE_LIST_FLUSH_RECOVERY_EN: defined -> flush sets head <= commit_head (plus commit_alloc of same cycle); alloc suppressed on flush cycle; free_we still honoured.
REQ-028 Undefined -> flush and commit_alloc ignored, commit_head logic removed; recovery is by rst only.

Structure
REQ-029 Shared package: NUM_PREGS, NUM_AREGS, preg index typedef (phys_reg_t), ptr typedef with wrap bit.
REQ-030 Single module; no sub-module; storage as flop array.

Verification
REQ-031 Reset, then 32 consecutive alloc_req -> alloc_pd 32,33,...,63 in order; then empty=1, alloc_valid=0, free_count=0.
REQ-032 Empty list, free_we free_pd=5 and alloc_req same cycle -> alloc denied; next cycle alloc_valid=1, alloc_pd=5.
REQ-033 Allocate 3 (32,33,34), commit_alloc once, flush (EN defined) -> next cycle alloc_pd=33, free_count=31.
REQ-034 Full list, alloc_req with free_we free_pd=7 -> count stays 32, head/tail both advance, 7 appears at wrap position 31.
REQ-035 free_we with free_pd=0 -> no change; free_count unchanged.
REQ-036 rst asserted mid-stream with alloc_req and free_we high -> next cycle alloc_pd=32, free_count=32.
